// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low segment codes (bit0=a .. bit6=g),
// special BCD values and the scan-reader FSM states.
package seg7_pkg;

    localparam logic [6:0] SEG_0 = 7'h40;
    localparam logic [6:0] SEG_1 = 7'h79;
    localparam logic [6:0] SEG_2 = 7'h24;
    localparam logic [6:0] SEG_3 = 7'h30;
    localparam logic [6:0] SEG_4 = 7'h19;
    localparam logic [6:0] SEG_5 = 7'h12;
    localparam logic [6:0] SEG_6 = 7'h02;
    localparam logic [6:0] SEG_7 = 7'h78;
    localparam logic [6:0] SEG_8 = 7'h00;
    localparam logic [6:0] SEG_9 = 7'h10;

    localparam logic [6:0] BLANK_CODE  = 7'h7F;
    localparam logic [3:0] BCD_BLANK   = 4'hF;
    localparam logic [3:0] BCD_INVALID = 4'hE;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational inverse of the segment table: active-low pattern to BCD digit.
// Blank maps to BCD_BLANK; anything unrecognised maps to BCD_INVALID with invalid_o set.
module seg7_to_bcd
    import seg7_pkg::*;
(
    input  logic [6:0] seg_n_i,
    output logic [3:0] bcd_o,
    output logic       invalid_o
);

    always_comb begin
        bcd_o     = BCD_INVALID;
        invalid_o = 1'b1;
        case (seg_n_i)
            SEG_0:      begin bcd_o = 4'd0;      invalid_o = 1'b0; end
            SEG_1:      begin bcd_o = 4'd1;      invalid_o = 1'b0; end
            SEG_2:      begin bcd_o = 4'd2;      invalid_o = 1'b0; end
            SEG_3:      begin bcd_o = 4'd3;      invalid_o = 1'b0; end
            SEG_4:      begin bcd_o = 4'd4;      invalid_o = 1'b0; end
            SEG_5:      begin bcd_o = 4'd5;      invalid_o = 1'b0; end
            SEG_6:      begin bcd_o = 4'd6;      invalid_o = 1'b0; end
            SEG_7:      begin bcd_o = 4'd7;      invalid_o = 1'b0; end
            SEG_8:      begin bcd_o = 4'd8;      invalid_o = 1'b0; end
            SEG_9:      begin bcd_o = 4'd9;      invalid_o = 1'b0; end
            BLANK_CODE: begin bcd_o = BCD_BLANK; invalid_o = 1'b0; end
            default:    ;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Reconstructs a multi-digit BCD value from a multiplexed active-low 7-segment bus:
// synchronise, wait for a stable one-hot dwell, capture per digit, publish full frames.
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS     = 4,
    parameter int STABLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_n,
    input  logic [NUM_DIGITS-1:0]   an_n,
    output logic [4*NUM_DIGITS-1:0] bcd_out,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    stale,
    output scan_state_e             dbg_state_o
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
    logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q, an_prev_q;
    scan_state_e             state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    capture;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d, err_q, err_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic                    fv_q, fv_d, ferr_q, ferr_d, stale_q, stale_d;
    logic [NUM_DIGITS-1:0]   an_act;
    logic                    one_hot, changed, publish, timeout;
    logic [IW-1:0]           idx;
    logic [3:0]              dec_bcd;
    logic                    dec_invalid;

    seg7_to_bcd u_dec (
        .seg_n_i   (seg_s2_q),
        .bcd_o     (dec_bcd),
        .invalid_o (dec_invalid)
    );

    assign an_act  = ~an_s2_q;
    assign one_hot = (an_act != '0) && ((an_act & (an_act - NUM_DIGITS'(1))) == '0);
    assign changed = (an_s2_q != an_prev_q) || (seg_s2_q != seg_prev_q);

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_s2_q[i]) idx = IW'(i);
        end
    end

    // Synchroniser, previous-sample register and FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1_q   <= BLANK_CODE;
            seg_s2_q   <= BLANK_CODE;
            seg_prev_q <= BLANK_CODE;
            an_s1_q    <= '1;
            an_s2_q    <= '1;
            an_prev_q  <= '1;
            state_q    <= SEARCH;
            cnt_q      <= '0;
        end else begin
            seg_s1_q   <= seg_n;
            seg_s2_q   <= seg_s1_q;
            seg_prev_q <= seg_s2_q;
            an_s1_q    <= an_n;
            an_s2_q    <= an_s1_q;
            an_prev_q  <= an_s2_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    // The count includes the current sample, so a fresh dwell starts at 1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            SEARCH: begin
                cnt_d = '0;
                if (one_hot) begin
                    state_d = SETTLE;
                    cnt_d   = CW'(1);
                end
            end
            SETTLE: begin
                if (changed) begin
                    state_d = one_hot ? SETTLE : SEARCH;
                    cnt_d   = one_hot ? CW'(1) : '0;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = HOLD;
                    cnt_d   = CW'(STABLE_CYCLES);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (changed) begin
                    state_d = one_hot ? SETTLE : SEARCH;
                    cnt_d   = one_hot ? CW'(1) : '0;
                end
            end
            default: begin
                state_d = SEARCH;
                cnt_d   = '0;
            end
        endcase
    end

    // Publish/timeout clear the mask first so a same-cycle capture survives.
    always_comb begin
        publish  = &mask_q;
        timeout  = (timer_q == TW'(TIMEOUT_CYCLES - 2)) && !publish;
        shadow_d = shadow_q;
        mask_d   = mask_q;
        err_d    = err_q;
        bcd_d    = bcd_q;
        ferr_d   = ferr_q;
        fv_d     = publish;
        stale_d  = timeout;
        timer_d  = (timer_q == TW'(TIMEOUT_CYCLES - 1)) ? '0 : timer_q + TW'(1);
        if (publish) begin
            bcd_d   = shadow_q;
            ferr_d  = |err_q;
            mask_d  = '0;
            err_d   = '0;
            timer_d = '0;
        end else if (timeout) begin
            mask_d = '0;
            err_d  = '0;
        end
        if (capture) begin
            shadow_d[4*int'(idx) +: 4] = dec_bcd;
            mask_d[idx]                = 1'b1;
            err_d[idx]                 = dec_invalid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            mask_q   <= '0;
            err_q    <= '0;
            bcd_q    <= '0;
            ferr_q   <= 1'b0;
            fv_q     <= 1'b0;
            stale_q  <= 1'b0;
            timer_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            err_q    <= err_d;
            bcd_q    <= bcd_d;
            ferr_q   <= ferr_d;
            fv_q     <= fv_d;
            stale_q  <= stale_d;
            timer_q  <= timer_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign frame_valid = fv_q;
    assign frame_err   = ferr_q;
    assign stale       = stale_q;
    assign dbg_state_o = state_q;

endmodule
